// File: rtl/mul_div_seq.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring) unit.
// One iteration per cycle over WIDTH cycles, then a sign-fix cycle, then a done pulse.
module mul_div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic                 div_zero,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               op_q, op_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    // acc holds the Booth A register or the division remainder; one extra bit
    // keeps Booth from overflowing when subtracting the most negative operand.
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               div_zero_q, div_zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     r_sh;
    logic [WIDTH+1:0]   diff;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        addend  = {m_q[WIDTH-1], m_q};
        unique case ({q_q[0], qm1_q})
            2'b01:   sum = acc_q + addend;
            2'b10:   sum = acc_q - addend;
            default: sum = acc_q;
        endcase
        r_sh    = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        diff    = {1'b0, r_sh} - {2'b00, m_q};
        quo_fix = (sa_q ^ sb_q) ? -q_q : q_q;
        rem_fix = sa_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        acc_d      = acc_q;
        q_d        = q_q;
        qm1_d      = qm1_q;
        m_d        = m_q;
        result_d   = result_q;
        div_zero_d = div_zero_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    op_d       = op;
                    sa_d       = a[WIDTH-1];
                    sb_d       = b[WIDTH-1];
                    cnt_d      = CW'(WIDTH);
                    acc_d      = '0;
                    qm1_d      = 1'b0;
                    div_zero_d = 1'b0;
                    state_d    = StRun;
                    if (op) begin
                        q_d = a[WIDTH-1] ? -a : a;
                        m_d = b[WIDTH-1] ? -b : b;
                        if (b == '0) begin
                            state_d    = StDone;
                            div_zero_d = 1'b1;
                            result_d   = {a, {WIDTH{1'b1}}};
                        end
                    end else begin
                        q_d = a;
                        m_d = b;
                    end
                end
            end
            StRun: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q) begin
                    // Restore on negative trial difference by keeping the shifted value.
                    acc_d = diff[WIDTH+1] ? r_sh : diff[WIDTH:0];
                    q_d   = {q_q[WIDTH-2:0], ~diff[WIDTH+1]};
                end else begin
                    acc_d = {sum[WIDTH], sum[WIDTH:1]};
                    q_d   = {sum[0], q_q[WIDTH-1:1]};
                    qm1_d = q_q[0];
                end
                if (cnt_q == CW'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                result_d = op_q ? {rem_fix, quo_fix} : {acc_q[WIDTH-1:0], q_q};
                state_d  = StDone;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StRun) || (state_d == StFix);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= 1'b0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            acc_q      <= '0;
            q_q        <= '0;
            qm1_q      <= 1'b0;
            m_q        <= '0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            acc_q      <= acc_d;
            q_q        <= q_d;
            qm1_q      <= qm1_d;
            m_q        <= m_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign result   = result_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Scoreboard bench for mul_div_seq: stimulus pushes expected results, a monitor
// pops and compares on every done pulse.
module tb_mul_div_seq;

    localparam int W = 32;

    logic           clock = 1'b0;
    logic           clear = 1'b1;
    logic           start = 1'b0;
    logic           op = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic           div_zero;
    logic [2*W-1:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2*W-1:0] res;
        logic           dz;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    mul_div_seq #(.WIDTH(W)) dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .result   (result)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!clear && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected done: got result %h expected no done", result);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", result, mon_e.res);
                check("div_zero", {63'd0, div_zero}, {63'd0, mon_e.dz});
            end
        end
    end

    // Drives start for one edge; returns #1 after the sampling edge.
    task automatic launch(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [63:0] r, input logic dz);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        exp_q.push_back('{res: r, dz: dz});
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat, input int exp_busy);
        int lat = 0;
        int bc  = 0;
        while (!done && lat < 200) begin
            bc += int'(busy);
            @(posedge clock);
            #1;
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " busy cycles"}, 64'(bc), 64'(exp_busy));
    endtask

    task automatic run(input string name, input logic o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [63:0] r, input logic dz);
        launch(o, x, y, r, dz);
        if (dz) wait_done(name, 0, 0);
        else    wait_done(name, 33, 33);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset div_zero", {63'd0, div_zero}, 64'd0);
        check("reset result", result, 64'd0);
        clear = 1'b0;
        @(posedge clock);
        #1;

        run("mul 3x4", 1'b0, 32'd3, 32'd4, 64'd12, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check("result held in idle", result, 64'd12);
        check("done low in idle", {63'd0, done}, 64'd0);

        run("mul -7x5", 1'b0, 32'hFFFFFFF9, 32'd5, 64'hFFFFFFFFFFFFFFDD, 1'b0);
        run("mul min x min", 1'b0, 32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b0);
        run("mul -1x-1", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1, 1'b0);
        run("div 24/12", 1'b1, 32'd24, 32'd12, 64'h0000000000000002, 1'b0);
        run("div -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFFFFFFFFFD, 1'b0);
        run("div 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001FFFFFFFD, 1'b0);
        run("div min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h0000000080000000, 1'b0);
        run("div 9/0", 1'b1, 32'd9, 32'd0, 64'h00000009FFFFFFFF, 1'b1);

        launch(1'b0, 32'd2, 32'd2, 64'd4, 1'b0);
        check("div_zero cleared by start", {63'd0, div_zero}, 64'd0);
        wait_done("mul 2x2", 33, 33);
        @(posedge clock);
        #1;

        // start pulsed mid-run must be ignored
        launch(1'b0, 32'd3, 32'd4, 64'd12, 1'b0);
        repeat (9) @(posedge clock);
        #1;
        op    = 1'b1;
        a     = 32'd100;
        b     = 32'd3;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done("mul with ignored start", 23, 23);
        launch(1'b1, 32'd100, 32'd3, 64'h0000000100000021, 1'b0);
        check("back-to-back done drops", {63'd0, done}, 64'd0);
        check("back-to-back busy", {63'd0, busy}, 64'd1);
        wait_done("div 100/3 back-to-back", 33, 33);
        @(posedge clock);
        #1;

        // clear mid-multiply aborts with no done pulse
        launch(1'b0, 32'd3, 32'd4, 64'd12, 1'b0);
        repeat (14) @(posedge clock);
        #1;
        clear = 1'b1;
        #1;
        exp_q.delete();
        check("clear busy", {63'd0, busy}, 64'd0);
        check("clear done", {63'd0, done}, 64'd0);
        check("clear result", result, 64'd0);
        check("clear div_zero", {63'd0, div_zero}, 64'd0);
        @(posedge clock);
        #1;
        clear = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        check("no done after clear", {63'd0, done}, 64'd0);
        run("mul 6x7 after clear", 1'b0, 32'd6, 32'd7, 64'd42, 1'b0);

        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
